reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core. Replaces the fixed 32x32, 2-read/1-write file.
- Adds:
  - configurable width, depth and read-port count;
  - a second write port for late load returns;
  - enable-qualified write-through bypass;
  - stall-time refresh of held outputs;
  - a per-register pending scoreboard used by the hazard unit.
- Sits between decode (read addresses, issue) and writeback (port A) / load-return path (port B).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending.
- AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_stall  in  1  hold read outputs.
- i_wa_en  in  1  write port A enable (writeback).
- i_wa_rd  in  AW  write port A address.
- i_wa_data  in  XLEN  write port A data.
- i_wb_en  in  1  write port B enable (load return); also clears pending.
- i_wb_rd  in  AW  write port B address.
- i_wb_data  in  XLEN  write port B data.
- i_rd_addr  in  NUM_RD*AW  packed read addresses; port k is bits [k*AW +: AW].
- o_rd_data  out  NUM_RD*XLEN  packed registered read data.
- o_rd_pend  out  NUM_RD  registered pending flag per read port.
- i_sb_set_en  in  1  mark a register pending (load issued).
- i_sb_set_rd  in  AW  register to mark.

Behaviour:
- Reset, asynchronous on i_rst_n low: all registers 0, all pending bits 0, o_rd_data 0, o_rd_pend 0, captured read addresses 0. Reset mid-operation discards in-flight writes and pending state immediately.
- Write enable: a write is effective when en=1 and not (ZERO_REG=1 and rd=0). Effective writes update the array at the rising edge.
- Write collision: both ports effective with equal rd → port B data is stored.
- Read latency: 1 cycle. When i_stall=0, each port k captures its address into addr_q[k]. o_rd_data[k] at the next edge = bypass value for i_rd_addr[k]:
  - port B data if port B is an effective write to that address;
  - else port A data if port A is an effective write to that address;
  - else the array contents.
  - Disabled or x0 writes never bypass.
  - ZERO_REG=1 with address 0 → 0.
- Stall (i_stall=1):
  - addr_q holds.
  - o_rd_data[k] holds, except when an effective write this cycle targets addr_q[k]. Then o_rd_data[k] updates to that write's data, with the same B>A priority.
  - o_rd_pend[k] is re-evaluated against addr_q[k] every cycle.
  - Array writes and scoreboard updates are never blocked by stall.
- Scoreboard, one bit per register:
  - Set by i_sb_set_en on i_sb_set_rd; ignored for register 0 when ZERO_REG=1.
  - Cleared by an effective port B write to that register.
  - Port A writes do not affect pending.
  - Same-cycle set and clear on the same register → set wins (bit stays 1).
- o_rd_pend[k] is registered with the same timing as o_rd_data. Its value is the pending bit of the selected address (i_rd_addr[k] when not stalled, addr_q[k] when stalled), computed as:
  - same-cycle port B clear applied;
  - same-cycle set not applied (a read in the issuing cycle sees the old state).
  - It is 0 for register 0 when ZERO_REG=1.
- ZERO_REG=0: register 0 behaves as any other register.
- Read ports are independent. Any number of ports may read the same address and see identical data.
- No combinational path from any input to any output.

Test Plan:
- Reset, then write A to x5 = 0x0000_1234. Next cycle read port0=x5 → o_rd_data[0]=0x0000_1234 one cycle later, o_rd_pend[0]=0.
- Same-cycle bypass: A writes x3=0xAAAA_0001, B writes x3=0xBBBB_0002, port0 and port1 both read x3 in that cycle → both outputs 0xBBBB_0002; a later plain read of x3 also returns 0xBBBB_0002.
- Disabled write: i_wa_en=0, i_wa_rd=x7, i_wa_data=0xDEAD_BEEF, read x7 (holding 0x11) → 0x11. Write of 0xFFFF_FFFF to x0 → reads of x0 return 0.
- Stall refresh: port1 captures x9=0x22, assert i_stall, A writes x9=0x33 → o_rd_data[1] becomes 0x33 while stalled. A write to x10 during the stall → o_rd_data[1] unchanged.
- Scoreboard:
  - i_sb_set_en on x4 → a read of x4 next cycle shows pend=1.
  - B writes x4=0x44 while reading x4 → pend=0 and data=0x44 in the same output cycle.
  - Simultaneous set and B-clear on x4 → x4 stays pending.
- Async reset mid-stream: assert i_rst_n=0 between edges with x4 pending and outputs non-zero → o_rd_data, o_rd_pend and the array are 0 immediately. Repeat with NUM_RD=4, XLEN=64, NREGS=16.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: decode-side read addresses,
// writeback port A, load-return port B, scoreboard set and registered read
// results. Clock and reset stay outside the bundle.
interface reg_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(NREGS);

  logic                     i_stall;
  logic                     i_wa_en;
  logic [AW-1:0]            i_wa_rd;
  logic [XLEN-1:0]          i_wa_data;
  logic                     i_wb_en;
  logic [AW-1:0]            i_wb_rd;
  logic [XLEN-1:0]          i_wb_data;
  logic [NUM_RD*AW-1:0]     i_rd_addr;
  logic [NUM_RD*XLEN-1:0]   o_rd_data;
  logic [NUM_RD-1:0]        o_rd_pend;
  logic                     i_sb_set_en;
  logic [AW-1:0]            i_sb_set_rd;

  // Pipeline side: drives addresses, writes and scoreboard sets.
  modport master (
    output i_stall, i_wa_en, i_wa_rd, i_wa_data,
    output i_wb_en, i_wb_rd, i_wb_data,
    output i_rd_addr, i_sb_set_en, i_sb_set_rd,
    input  o_rd_data, o_rd_pend
  );

  // Register file side.
  modport slave (
    input  i_stall, i_wa_en, i_wa_rd, i_wa_data,
    input  i_wb_en, i_wb_rd, i_wb_data,
    input  i_rd_addr, i_sb_set_en, i_sb_set_rd,
    output o_rd_data, o_rd_pend
  );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with two write ports
// (writeback A, load return B), write-through bypass, stall-time refresh of
// held read outputs and a per-register pending scoreboard for the hazard unit.
// All outputs are registered; nothing flows combinationally to an output.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic ZR = (ZERO_REG != 0);

  // True when the address is the hardwired zero register.
  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZR && (a == {AW{1'b0}});
  endfunction

  logic [XLEN-1:0]        mem_r [NREGS];
  logic [NREGS-1:0]       pend_r;
  logic [AW-1:0]          addr_q_r [NUM_RD];
  logic [NUM_RD*XLEN-1:0] rd_data_r;
  logic [NUM_RD-1:0]      rd_pend_r;

  logic                   wa_eff_s;
  logic                   wb_eff_s;
  logic                   set_eff_s;
  logic [NREGS-1:0]       pend_nxt_s;
  logic [AW-1:0]          sel_s [NUM_RD];
  logic [NUM_RD-1:0]      hit_a_s;
  logic [NUM_RD-1:0]      hit_b_s;
  logic [NUM_RD*XLEN-1:0] rd_data_nxt_s;
  logic [NUM_RD-1:0]      rd_pend_nxt_s;

  // Qualify write and scoreboard-set enables; register 0 is never touched when hardwired.
  always_comb begin
    wa_eff_s  = bus.i_wa_en     && !is_zero_reg(bus.i_wa_rd);
    wb_eff_s  = bus.i_wb_en     && !is_zero_reg(bus.i_wb_rd);
    set_eff_s = bus.i_sb_set_en && !is_zero_reg(bus.i_sb_set_rd);
  end

  // Next scoreboard state: a load return clears, a new load issue sets, set wins on a tie.
  always_comb begin
    pend_nxt_s = pend_r;
    if (wb_eff_s) begin
      pend_nxt_s[bus.i_wb_rd] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (set_eff_s) begin
      pend_nxt_s[bus.i_sb_set_rd] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
  end

  // Per read port: pick the live or held address, then resolve data (B over A over array/held) and pending.
  always_comb begin
    hit_a_s       = {NUM_RD{1'b0}};
    hit_b_s       = {NUM_RD{1'b0}};
    rd_data_nxt_s = rd_data_r;
    rd_pend_nxt_s = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (bus.i_stall) begin
        sel_s[k] = addr_q_r[k];
      end else begin
        sel_s[k] = bus.i_rd_addr[k*AW +: AW];
      end
      hit_a_s[k] = wa_eff_s && (bus.i_wa_rd == sel_s[k]);
      hit_b_s[k] = wb_eff_s && (bus.i_wb_rd == sel_s[k]);

      if (hit_b_s[k]) begin
        rd_data_nxt_s[k*XLEN +: XLEN] = bus.i_wb_data;
      end else if (hit_a_s[k]) begin
        rd_data_nxt_s[k*XLEN +: XLEN] = bus.i_wa_data;
      end else if (bus.i_stall) begin
        rd_data_nxt_s[k*XLEN +: XLEN] = rd_data_r[k*XLEN +: XLEN];
      end else if (is_zero_reg(sel_s[k])) begin
        rd_data_nxt_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
      end else begin
        rd_data_nxt_s[k*XLEN +: XLEN] = mem_r[sel_s[k]];
      end

      // The same-cycle set is deliberately not visible: an issuing read sees the old state.
      if (is_zero_reg(sel_s[k])) begin
        rd_pend_nxt_s[k] = 1'b0;
      end else if (hit_b_s[k]) begin
        rd_pend_nxt_s[k] = 1'b0;
      end else begin
        rd_pend_nxt_s[k] = pend_r[sel_s[k]];
      end
    end
  end

  // Register array: port A then port B, so B's data lands on an address collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      if (wa_eff_s) begin
        mem_r[bus.i_wa_rd] <= bus.i_wa_data;
      end
      if (wb_eff_s) begin
        mem_r[bus.i_wb_rd] <= bus.i_wb_data;
      end
    end
  end

  // Pending scoreboard register; stall never blocks updates.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_r <= {NREGS{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Captured read addresses, frozen while stalled so held outputs can be refreshed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_RD; k++) begin
        addr_q_r[k] <= {AW{1'b0}};
      end
    end else if (!bus.i_stall) begin
      for (int k = 0; k < NUM_RD; k++) begin
        addr_q_r[k] <= bus.i_rd_addr[k*AW +: AW];
      end
    end
  end

  // Registered read data and pending flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_r <= {(NUM_RD*XLEN){1'b0}};
      rd_pend_r <= {NUM_RD{1'b0}};
    end else begin
      rd_data_r <= rd_data_nxt_s;
      rd_pend_r <= rd_pend_nxt_s;
    end
  end

  assign bus.o_rd_data = rd_data_r;
  assign bus.o_rd_pend = rd_pend_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: drives a default instance (32x32, 2 ports) and a
// wide instance (16x64, 4 ports) with identical stimulus. Expected outputs
// are pushed to a queue when a cycle is driven and compared after the edge.
module tb_reg_file_mp;

  typedef struct packed {
    logic [3:0][63:0] d;
    logic [3:0]       p;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        wa_en, wb_en, sb_en;
  logic [4:0]  wa_rd, wb_rd, sb_rd;
  logic [63:0] wa_data, wb_data;
  logic [4:0]  ra [4];

  int errors = 0;
  int checks = 0;

  exp_t        exp_q [$];
  logic [63:0] m_mem  [16];
  logic [15:0] m_pend;
  logic [3:0]  m_aq   [4];
  logic [63:0] m_out  [4];

  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) if0 ();
  reg_file_mp_if #(.XLEN(64), .NREGS(16), .NUM_RD(4)) if1 ();

  assign if0.i_stall     = stall;
  assign if0.i_wa_en     = wa_en;
  assign if0.i_wa_rd     = wa_rd;
  assign if0.i_wa_data   = wa_data[31:0];
  assign if0.i_wb_en     = wb_en;
  assign if0.i_wb_rd     = wb_rd;
  assign if0.i_wb_data   = wb_data[31:0];
  assign if0.i_rd_addr   = {ra[1], ra[0]};
  assign if0.i_sb_set_en = sb_en;
  assign if0.i_sb_set_rd = sb_rd;

  assign if1.i_stall     = stall;
  assign if1.i_wa_en     = wa_en;
  assign if1.i_wa_rd     = wa_rd[3:0];
  assign if1.i_wa_data   = wa_data;
  assign if1.i_wb_en     = wb_en;
  assign if1.i_wb_rd     = wb_rd[3:0];
  assign if1.i_wb_data   = wb_data;
  assign if1.i_rd_addr   = {ra[3][3:0], ra[2][3:0], ra[1][3:0], ra[0][3:0]};
  assign if1.i_sb_set_en = sb_en;
  assign if1.i_sb_set_rd = sb_rd[3:0];

  reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .ZERO_REG(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if0)
  );
  reg_file_mp #(.XLEN(64), .NREGS(16), .NUM_RD(4), .ZERO_REG(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if1)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, want);
    end
  endtask

  // 64-bit write data derived from a 32-bit value so the wide instance sees distinct upper bits.
  function automatic logic [63:0] ext(input logic [31:0] x);
    return {~x, x};
  endfunction

  task automatic idle();
    stall = 1'b0; wa_en = 1'b0; wb_en = 1'b0; sb_en = 1'b0;
    wa_rd = 5'd0; wb_rd = 5'd0; sb_rd = 5'd0;
    wa_data = 64'd0; wb_data = 64'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 64'd0;
    m_pend = 16'd0;
    for (int k = 0; k < 4; k++) begin
      m_aq[k] = 4'd0;
      m_out[k] = 64'd0;
    end
  endtask

  // Predict this cycle's outputs, advance the model, clock once and score both instances.
  task automatic step();
    exp_t e;
    logic ea, eb;
    logic [3:0] s;
    ea = wa_en && (wa_rd != 5'd0);
    eb = wb_en && (wb_rd != 5'd0);
    for (int k = 0; k < 4; k++) begin
      s = stall ? m_aq[k] : ra[k][3:0];
      if (eb && wb_rd[3:0] == s)      e.d[k] = wb_data;
      else if (ea && wa_rd[3:0] == s) e.d[k] = wa_data;
      else if (stall)                 e.d[k] = m_out[k];
      else if (s == 4'd0)             e.d[k] = 64'd0;
      else                            e.d[k] = m_mem[s];
      if (s == 4'd0)                  e.p[k] = 1'b0;
      else if (eb && wb_rd[3:0] == s) e.p[k] = 1'b0;
      else                            e.p[k] = m_pend[s];
    end
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (!stall) m_aq[k] = ra[k][3:0];
      m_out[k] = e.d[k];
    end
    if (ea) m_mem[wa_rd[3:0]] = wa_data;
    if (eb) m_mem[wb_rd[3:0]] = wb_data;
    if (eb) m_pend[wb_rd[3:0]] = 1'b0;
    if (sb_en && sb_rd != 5'd0) m_pend[sb_rd[3:0]] = 1'b1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("d0_data%0d", k), {32'd0, if0.o_rd_data[k*32 +: 32]}, {32'd0, e.d[k][31:0]});
      check_eq($sformatf("d0_pend%0d", k), {63'd0, if0.o_rd_pend[k]}, {63'd0, e.p[k]});
    end
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("d1_data%0d", k), if1.o_rd_data[k*64 +: 64], e.d[k]);
      check_eq($sformatf("d1_pend%0d", k), {63'd0, if1.o_rd_pend[k]}, {63'd0, e.p[k]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_d0_data"}, {32'd0, if0.o_rd_data}, 64'd0);
    check_eq({tag, "_d0_pend"}, {62'd0, if0.o_rd_pend}, 64'd0);
    check_eq({tag, "_d1_data_lo"}, if1.o_rd_data[127:0] == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    check_eq({tag, "_d1_data_hi"}, if1.o_rd_data[255:128] == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    check_eq({tag, "_d1_pend"}, {60'd0, if1.o_rd_pend}, 64'd0);
  endtask

  // Directed scenarios followed by a randomised stretch.
  initial begin
    rst_n = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) ra[k] = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic write then read.
    idle(); wa_en = 1'b1; wa_rd = 5'd5; wa_data = ext(32'h0000_1234); step();
    idle(); ra[0] = 5'd5; step();
    check_eq("read_x5", {32'd0, if0.o_rd_data[31:0]}, 64'h0000_0000_0000_1234);
    check_eq("read_x5_pend", {63'd0, if0.o_rd_pend[0]}, 64'd0);

    // Both write ports hit x3 while both read ports read it.
    idle(); ra[0] = 5'd3; ra[1] = 5'd3;
    wa_en = 1'b1; wa_rd = 5'd3; wa_data = ext(32'hAAAA_0001);
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = ext(32'hBBBB_0002); step();
    check_eq("bypass_p0", {32'd0, if0.o_rd_data[31:0]}, 64'h0000_0000_BBBB_0002);
    check_eq("bypass_p1", {32'd0, if0.o_rd_data[63:32]}, 64'h0000_0000_BBBB_0002);
    idle(); ra[0] = 5'd3; ra[1] = 5'd0; step();
    check_eq("x3_stored", {32'd0, if0.o_rd_data[31:0]}, 64'h0000_0000_BBBB_0002);

    // Disabled write and writes to x0 never land or bypass.
    idle(); wa_en = 1'b1; wa_rd = 5'd7; wa_data = ext(32'h0000_0011); step();
    idle(); wa_rd = 5'd7; wa_data = ext(32'hDEAD_BEEF); ra[0] = 5'd7; step();
    check_eq("disabled_wr", {32'd0, if0.o_rd_data[31:0]}, 64'h0000_0000_0000_0011);
    idle(); wa_en = 1'b1; wa_rd = 5'd0; wa_data = ext(32'hFFFF_FFFF); ra[1] = 5'd0; step();
    check_eq("x0_bypass", {32'd0, if0.o_rd_data[63:32]}, 64'd0);
    idle(); ra[0] = 5'd0; step();
    check_eq("x0_read", {32'd0, if0.o_rd_data[31:0]}, 64'd0);

    // Stall refresh of a held output.
    idle(); wa_en = 1'b1; wa_rd = 5'd9; wa_data = ext(32'h0000_0022); step();
    idle(); ra[1] = 5'd9; step();
    check_eq("stall_cap", {32'd0, if0.o_rd_data[63:32]}, 64'h0000_0000_0000_0022);
    idle(); stall = 1'b1; ra[1] = 5'd1;
    wa_en = 1'b1; wa_rd = 5'd9; wa_data = ext(32'h0000_0033); step();
    check_eq("stall_refresh", {32'd0, if0.o_rd_data[63:32]}, 64'h0000_0000_0000_0033);
    idle(); stall = 1'b1; wa_en = 1'b1; wa_rd = 5'd10; wa_data = ext(32'h0000_0099); step();
    check_eq("stall_other", {32'd0, if0.o_rd_data[63:32]}, 64'h0000_0000_0000_0033);

    // Scoreboard set, load-return clear, and set winning over clear.
    idle(); sb_en = 1'b1; sb_rd = 5'd4; ra[0] = 5'd4; step();
    check_eq("pend_old_state", {63'd0, if0.o_rd_pend[0]}, 64'd0);
    idle(); ra[0] = 5'd4; step();
    check_eq("pend_set", {63'd0, if0.o_rd_pend[0]}, 64'd1);
    idle(); ra[0] = 5'd4; wb_en = 1'b1; wb_rd = 5'd4; wb_data = ext(32'h0000_0044); step();
    check_eq("pend_clr", {63'd0, if0.o_rd_pend[0]}, 64'd0);
    check_eq("pend_clr_data", {32'd0, if0.o_rd_data[31:0]}, 64'h0000_0000_0000_0044);
    idle(); sb_en = 1'b1; sb_rd = 5'd4; wb_en = 1'b1; wb_rd = 5'd4; wb_data = ext(32'h0000_0045); step();
    idle(); ra[0] = 5'd4; wa_en = 1'b1; wa_rd = 5'd4; wa_data = ext(32'h0000_0046); step();
    check_eq("set_wins", {63'd0, if0.o_rd_pend[0]}, 64'd1);
    check_eq("porta_no_clr_data", {32'd0, if0.o_rd_data[31:0]}, 64'h0000_0000_0000_0046);

    // Asynchronous reset between edges with live state.
    idle(); ra[0] = 5'd4; ra[1] = 5'd5; ra[2] = 5'd3; ra[3] = 5'd9; step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #2;
    rst_n = 1'b1;
    idle(); ra[0] = 5'd4; ra[1] = 5'd5; ra[2] = 5'd9; ra[3] = 5'd3; step();
    check_eq("post_rst_x4", {32'd0, if0.o_rd_data[31:0]}, 64'd0);
    check_eq("post_rst_pend", {63'd0, if0.o_rd_pend[0]}, 64'd0);

    // Randomised traffic over a small address range to force collisions.
    for (int n = 0; n < 80; n++) begin
      stall   = ($urandom_range(0, 3) == 0);
      wa_en   = $urandom_range(0, 1) == 1;
      wa_rd   = 5'($urandom_range(0, 7));
      wa_data = {$urandom, $urandom};
      wb_en   = $urandom_range(0, 2) == 0;
      wb_rd   = 5'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      sb_en   = $urandom_range(0, 2) == 0;
      sb_rd   = 5'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) ra[k] = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
